// File: rtl/ccg_pkg.sv
// ccg_pkg: opcodes, slot configuration type and reset defaults for the gate array
package ccg_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;
  typedef struct packed {
    op_e        op;
    logic [4:0] a;
    logic [4:0] b;
  } slot_cfg_t;
  function automatic slot_cfg_t slot_default(int slot, int n_in);
    slot_cfg_t c;
    c.op = OP_BUF;
    c.a  = 5'(slot % n_in);
    c.b  = '0;
    return c;
  endfunction
endpackage

// File: rtl/ccg_gate_slot.sv
// ccg_gate_slot: combinational evaluator for one programmable two-input gate
module ccg_gate_slot
  import ccg_pkg::*;
(
  input  logic [31:0] x,
  input  slot_cfg_t   cfg,
  output logic        y
);
  logic a, b;
  always_comb begin
    a = x[cfg.a];
    b = x[cfg.b];
    y = 1'b0;
    case (cfg.op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_BUF:  y = a;
      OP_NOT:  y = ~a;
    endcase
  end
endmodule

// File: rtl/ccg_prog_gate_array.sv
// ccg_prog_gate_array: two-stage pipelined array of N_OUT programmable gates over N_IN inputs
module ccg_prog_gate_array
  import ccg_pkg::*;
#(
  parameter int N_IN  = 6,
  parameter int N_OUT = 18,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [5:0]       cfg_idx,
  input  logic [2:0]       cfg_op,
  input  logic [4:0]       cfg_a,
  input  logic [4:0]       cfg_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f,
  output logic [CNT_W-1:0] res_cnt,
  output logic             cfg_err
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [N_IN-1:0]  s1_x_q, s1_x_d;
  logic [N_OUT-1:0] f_q, f_d, f_new;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  slot_cfg_t        slot_q [N_OUT];
  slot_cfg_t        slot_d [N_OUT];
  slot_cfg_t        wr_cfg;
  logic             s1_stall, s2_stall, cfg_busy, in_hs, idx_ok;
  logic [31:0]      xe;
  // zero-padding makes any operand index >= N_IN read as constant 0
  assign xe = 32'(s1_x_q);
  always_comb begin
    s2_stall   = s2_valid_q && !out_ready;
    s1_stall   = s1_valid_q && s2_stall;
    cfg_ready  = !rst && !s1_valid_q && !s2_valid_q;
    cfg_busy   = cfg_valid && cfg_ready;
    in_ready   = !rst && !cfg_busy && !s1_stall;
    in_hs      = in_valid && in_ready;
    s1_valid_d = s1_stall ? s1_valid_q : in_hs;
    s1_x_d     = in_hs ? x : s1_x_q;
    s2_valid_d = s2_stall ? s2_valid_q : s1_valid_q;
    f_d        = (!s2_stall && s1_valid_q) ? f_new : f_q;
    res_cnt_d  = res_cnt_q + CNT_W'(s2_valid_q && out_ready);
    idx_ok     = 32'(cfg_idx) < N_OUT;
    cfg_err_d  = cfg_err_q || (cfg_busy && !idx_ok);
    wr_cfg.op  = op_e'(cfg_op);
    wr_cfg.a   = cfg_a;
    wr_cfg.b   = cfg_b;
    for (int i = 0; i < N_OUT; i++)
      slot_d[i] = (cfg_busy && 32'(cfg_idx) == i) ? wr_cfg : slot_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_x_q     <= '0;
      f_q        <= '0;
      res_cnt_q  <= '0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < N_OUT; i++) slot_q[i] <= slot_default(i, N_IN);
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_x_q     <= s1_x_d;
      f_q        <= f_d;
      res_cnt_q  <= res_cnt_d;
      cfg_err_q  <= cfg_err_d;
      for (int i = 0; i < N_OUT; i++) slot_q[i] <= slot_d[i];
    end
  end
  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    ccg_gate_slot u_slot (.x(xe), .cfg(slot_q[g]), .y(f_new[g]));
  end
  assign out_valid = s2_valid_q;
  assign f         = f_q;
  assign res_cnt   = res_cnt_q;
  assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_ccg_prog_gate_array.sv
// tb_ccg_prog_gate_array: directed and random checks against a queue-based reference model
module tb_ccg_prog_gate_array;
  localparam int NI = 6, NO = 18, CW = 4;
  logic clk = 0, rst = 1;
  logic cfg_valid = 0, cfg_ready;
  logic [5:0] cfg_idx = 0;
  logic [2:0] cfg_op = 0;
  logic [4:0] cfg_a = 0, cfg_b = 0;
  logic in_valid = 0, in_ready;
  logic [NI-1:0] x = 0;
  logic out_valid, out_ready = 1;
  logic [NO-1:0] f;
  logic [CW-1:0] res_cnt;
  logic cfg_err;

  ccg_prog_gate_array #(.N_IN(NI), .N_OUT(NO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_op(cfg_op), .cfg_a(cfg_a), .cfg_b(cfg_b), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .out_valid(out_valid), .out_ready(out_ready), .f(f), .res_cnt(res_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [NO-1:0] f; int t;} ent_t;
  ent_t q[$];
  int m_op[NO], m_a[NO], m_b[NO];
  int n_checks = 0, n_err = 0, cyc = 0, cnt = 0;
  logic err = 0;
  logic [NO-1:0] last_f = '0;
  bit acc, cacc;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NO; i++) begin
      m_op[i] = 6; m_a[i] = i % NI; m_b[i] = 0;
    end
    cnt = 0; err = 0; last_f = '0;
  endfunction

  function automatic logic [NO-1:0] eval_all(logic [NI-1:0] xv);
    logic [NO-1:0] r;
    logic va, vb;
    for (int i = 0; i < NO; i++) begin
      va = (m_a[i] < NI) ? xv[m_a[i]] : 1'b0;
      vb = (m_b[i] < NI) ? xv[m_b[i]] : 1'b0;
      case (m_op[i])
        0: r[i] = va & vb;
        1: r[i] = va | vb;
        2: r[i] = va ^ vb;
        3: r[i] = !(va & vb);
        4: r[i] = !(va | vb);
        5: r[i] = va == vb;
        6: r[i] = va;
        default: r[i] = !va;
      endcase
    end
    return r;
  endfunction

  // one clock cycle: compare DUT against model at negedge, then advance the model
  task automatic tick();
    logic ov, cr, ir;
    ent_t e;
    @(negedge clk);
    acc = 0; cacc = 0;
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_cfg_ready", cfg_ready, 0);
      @(posedge clk); #1;
      cyc++; q.delete(); model_reset();
      return;
    end
    ov = 0;
    if (q.size() > 0) ov = cyc >= q[0].t + 2;
    cr = q.size() == 0;
    ir = !(cfg_valid && cr) && (q.size() < 2 || out_ready);
    check("out_valid", out_valid, ov);
    check("f", f, ov ? q[0].f : last_f);
    check("res_cnt", res_cnt, cnt);
    check("cfg_err", cfg_err, err);
    check("cfg_ready", cfg_ready, cr);
    check("in_ready", in_ready, ir);
    if (ov && out_ready) begin
      last_f = q[0].f; void'(q.pop_front()); cnt = (cnt + 1) % (1 << CW);
    end
    if (cfg_valid && cr) begin
      cacc = 1;
      if (cfg_idx < NO) begin
        m_op[cfg_idx] = cfg_op; m_a[cfg_idx] = cfg_a; m_b[cfg_idx] = cfg_b;
      end else err = 1;
    end
    if (in_valid && ir) begin
      acc = 1; e.f = eval_all(x); e.t = cyc; q.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send(logic [NI-1:0] v);
    bit got = 0;
    in_valid = 1; x = v;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(); got = acc;
    end
    in_valid = 0;
    check("send_timeout", got, 1);
  endtask

  task automatic cfg_write(int idx, int op, int a, int b);
    bit got = 0;
    cfg_valid = 1; cfg_idx = 6'(idx); cfg_op = 3'(op); cfg_a = 5'(a); cfg_b = 5'(b);
    for (int i = 0; i < 20 && !got; i++) begin
      tick(); got = cacc;
    end
    cfg_valid = 0;
    check("cfg_timeout", got, 1);
  endtask

  task automatic drain();
    in_valid = 0; cfg_valid = 0; out_ready = 1;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    logic [NI-1:0] v[4];
    int k;
    model_reset();
    rst = 1; tick(); tick(); rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_f", f, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_cfg_err", cfg_err, 0);
    // default BUF wiring and two-cycle latency
    out_ready = 1;
    send(6'b101101);
    tick();
    check("lat_out_valid", out_valid, 1);
    check("lat_f", f, 18'h2DB6D);
    tick();
    check("lat_res_cnt", res_cnt, 1);
    drain();
    // slot 0 as XOR of inputs 1 and 3
    cfg_write(0, 2, 1, 3);
    send(6'b001010); drain();
    check("xor_f0_zero", f[0], 0);
    send(6'b000010); drain();
    check("xor_f0_one", f[0], 1);
    // back-to-back vectors with a three-cycle output stall
    v = '{6'h15, 6'h2A, 6'h3C, 6'h07};
    k = 0; in_valid = 1;
    for (int t = 0; t < 30 && k < 4; t++) begin
      x = v[k]; out_ready = !(t >= 2 && t < 5);
      tick();
      if (acc) k++;
    end
    check("b2b_accepted", k, 4);
    drain();
    // configuration waits for a full pipeline to drain
    out_ready = 0;
    send(6'h11); send(6'h22);
    cfg_valid = 1; cfg_idx = 5; cfg_op = 7; cfg_a = 2; cfg_b = 0;
    #1;
    check("cfg_blocked", cfg_ready, 0);
    tick(); tick();
    out_ready = 1;
    cfg_write(5, 7, 2, 0);
    drain();
    // configuration has priority over a simultaneous input
    cfg_valid = 1; cfg_idx = 7; cfg_op = 0; cfg_a = 0; cfg_b = 1;
    in_valid = 1; x = 6'h03;
    #1;
    check("prio_cfg_ready", cfg_ready, 1);
    check("prio_in_ready", in_ready, 0);
    tick();
    cfg_valid = 0;
    #1;
    check("prio_in_ready_next", in_ready, 1);
    tick();
    in_valid = 0;
    drain();
    // bad slot index and out-of-range operand
    cfg_write(40, 2, 1, 3);
    check("bad_idx_err", cfg_err, 1);
    send(6'h3F); drain();
    cfg_write(2, 6, 31, 0);
    send(6'h3F); drain();
    check("a31_f2", f[2], 0);
    check("err_sticky", cfg_err, 1);
    // counter wrap with 17 results
    do_reset();
    for (int i = 0; i < 17; i++) send(NI'($urandom));
    drain();
    check("cnt_wrap", res_cnt, 1);
    // reset with two vectors in flight restores defaults
    out_ready = 0;
    cfg_write(4, 3, 0, 1);
    send(6'h2B); send(6'h14);
    rst = 1; tick(); rst = 0;
    check("flight_out_valid", out_valid, 0);
    check("flight_cnt", res_cnt, 0);
    out_ready = 1;
    send(6'b110010); drain();
    check("flight_default_f", f, {3{6'b110010}});
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      x = NI'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      cfg_valid = $urandom_range(0, 15) == 0;
      cfg_idx = 6'($urandom_range(0, 20));
      cfg_op = 3'($urandom);
      cfg_a = 5'($urandom_range(0, 7));
      cfg_b = 5'($urandom_range(0, 7));
      rst = $urandom_range(0, 99) == 0;
      tick();
    end
    rst = 0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
